// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO edge-interrupt block: register indices and default width.
package gpio_pkg;

  localparam int unsigned GPIO_WIDTH = 32;

  // Register indices decoded from HADDR
  localparam logic [1:0] GPIO_IN      = 2'd0;
  localparam logic [1:0] GPIO_IRQ_EN  = 2'd1;
  localparam logic [1:0] GPIO_IRQ_POL = 2'd2;
  localparam logic [1:0] GPIO_STATUS  = 2'd3;

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit input conditioner: multi-flop synchroniser, debounce counter and stable flop.
// 'change' is high in the cycle before the edge on which 'stable' takes the new value.
module gpio_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic change
);

  localparam int unsigned CntW = $clog2(DB_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   stable_q, stable_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign stable   = stable_q;

  // Synchroniser chain: bit 0 samples the raw pin, the top bit is the chain output
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  // Debounce next state: count consecutive mismatches, accept on the DB_CYCLES-th one
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    change   = 1'b0;
    if (sync_out != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync_out;
        change   = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/gpio_edge_irq.sv
// GPIO input edge detector: per-pin conditioning, polarity-qualified edge events latched into
// a write-1-to-clear STATUS register, and a single level interrupt. Simple single-cycle bus.
module gpio_edge_irq
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = GPIO_WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [1:0]       HADDR,
  input  logic             HWRITE,
  input  logic [WIDTH-1:0] HWDATA,
  output logic [WIDTH-1:0] HRDATA,
  input  logic [WIDTH-1:0] pins,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] change;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] irq_pol_q, irq_pol_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_debounce (
      .clk    (HCLK),
      .rst    (HRESET),
      .pin    (pins[i]),
      .stable (stable[i]),
      .change (change[i])
    );
  end

  assign wr_en = HSEL & HWRITE;

  // A change flips stable, so its old value tells the direction: old 0 is a rise (pol=1),
  // old 1 is a fall (pol=0). Hence an event wherever old stable differs from pol.
  assign edge_evt = change & (stable ^ irq_pol_q);

  // Register next state: bus writes, then W1C clear with event set taking priority
  always_comb begin
    irq_en_d  = irq_en_q;
    irq_pol_d = irq_pol_q;
    clr       = '0;
    if (wr_en) begin
      case (HADDR)
        GPIO_IRQ_EN:  irq_en_d  = HWDATA;
        GPIO_IRQ_POL: irq_pol_d = HWDATA;
        GPIO_STATUS:  clr       = HWDATA;
        default:      ;
      endcase
    end
    status_d = (status_q & ~clr) | edge_evt;
  end

  // Control and status registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_en_q  <= '0;
      irq_pol_q <= '0;
      status_q  <= '0;
    end else begin
      irq_en_q  <= irq_en_d;
      irq_pol_q <= irq_pol_d;
      status_q  <= status_d;
    end
  end

  // Read mux, combinational from HADDR
  always_comb begin
    HRDATA = '0;
    case (HADDR)
      GPIO_IN:      HRDATA = stable;
      GPIO_IRQ_EN:  HRDATA = irq_en_q;
      GPIO_IRQ_POL: HRDATA = irq_pol_q;
      GPIO_STATUS:  HRDATA = status_q;
      default:      HRDATA = '0;
    endcase
  end

  assign irq = |(status_q & irq_en_q);

endmodule
